// File: rtl/uart_regf_arb.sv
// -----------------------------------------------------------------------------
// uart_regf_arb
//
// Two-port round-robin arbiter and access sequencer for the UART register
// file's memory-style bus. Port A is the host bus bridge and port B is the
// UART core's configuration sequencer. One access is in flight at a time.
// Each access runs IDLE -> ACCESS -> CAPT -> RESP, which gives one access
// every four cycles.
//
// Ports:
//   main_clk_i, main_rst_an_i     clock, synchronous active-low reset
//   a_req_i/a_addr_i/a_wena_i/a_wdata_i
//                                 port A request, word address, write
//                                 enable and write data
//   a_gnt_o                       port A accepted (combinational, IDLE only)
//   a_rvalid_o/a_rdata_o/a_err_o  port A response (registered 1-cycle pulse)
//   b_*                           same set for port B
//   mem_ena_o/mem_addr_o/mem_wena_o/mem_wdata_o
//                                 regf access, active in ACCESS only
//   mem_rdata_i                   regf read data, valid the cycle after
//                                 mem_ena_o
// -----------------------------------------------------------------------------
module uart_regf_arb #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned NUM_WORDS = 1
) (
    input  logic          main_clk_i,
    input  logic          main_rst_an_i,
    // Port A: host bus bridge
    input  logic          a_req_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic          a_wena_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic          a_gnt_o,
    output logic          a_rvalid_o,
    output logic [DW-1:0] a_rdata_o,
    output logic          a_err_o,
    // Port B: configuration sequencer
    input  logic          b_req_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic          b_wena_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic          b_gnt_o,
    output logic          b_rvalid_o,
    output logic [DW-1:0] b_rdata_o,
    output logic          b_err_o,
    // Register file bus
    output logic          mem_ena_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_wena_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StCapt   = 2'd2,
        StResp   = 2'd3
    } state_e;

    // One extra bit keeps the range check correct when NUM_WORDS == 2**AW.
    localparam logic [AW:0] NumWordsCmp = (AW + 1)'(NUM_WORDS);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;       // 0: A holds priority, 1: B holds priority
    logic          id_q, id_d;         // winner of the current access, 1 = B
    logic          err_q, err_d;
    logic          wena_q, wena_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          mem_ena_q, mem_ena_d;
    logic          mem_wena_q, mem_wena_d;

    logic          a_rvalid_q, a_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic          a_err_q, a_err_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          b_err_q, b_err_d;

    logic          idle;
    logic          a_win, b_win;
    logic [AW-1:0] sel_addr;
    logic          sel_wena;
    logic [DW-1:0] sel_wdata;
    logic          sel_err;
    logic [DW-1:0] resp_data;

    // -------------------------------------------------------------------------
    // Arbitration. A lone requester always wins; on a tie the priority holder
    // wins. Grants are masked by reset so nothing is accepted during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        idle  = (state_q == StIdle);
        a_win = main_rst_an_i & idle & a_req_i & (~b_req_i | ~ptr_q);
        b_win = main_rst_an_i & idle & b_req_i & (~a_req_i |  ptr_q);

        sel_addr  = b_win ? b_addr_i  : a_addr_i;
        sel_wena  = b_win ? b_wena_i  : a_wena_i;
        sel_wdata = b_win ? b_wdata_i : a_wdata_i;
        sel_err   = ({1'b0, sel_addr} >= NumWordsCmp);

        // Writes and out-of-range accesses return zero data.
        resp_data = (~err_q & ~wena_q) ? mem_rdata_i : '0;
    end

    assign a_gnt_o = a_win;
    assign b_gnt_o = b_win;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        err_d      = err_q;
        wena_d     = wena_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        // Strobes and response pulses default low every cycle.
        mem_ena_d  = 1'b0;
        mem_wena_d = 1'b0;
        a_rvalid_d = 1'b0;
        a_rdata_d  = '0;
        a_err_d    = 1'b0;
        b_rvalid_d = 1'b0;
        b_rdata_d  = '0;
        b_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (a_win || b_win) begin
                    id_d       = b_win;
                    addr_d     = sel_addr;
                    wena_d     = sel_wena;
                    wdata_d    = sel_wdata;
                    err_d      = sel_err;
                    // Priority moves to whichever port was not granted.
                    ptr_d      = a_win;
                    // Strobes are registered so they are high during ACCESS.
                    mem_ena_d  = ~sel_err;
                    mem_wena_d = ~sel_err & sel_wena;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                state_d = StCapt;
            end
            StCapt: begin
                // Response registers load here so rvalid is high during RESP.
                if (id_q) begin
                    b_rvalid_d = 1'b1;
                    b_rdata_d  = resp_data;
                    b_err_d    = err_q;
                end else begin
                    a_rvalid_d = 1'b1;
                    a_rdata_d  = resp_data;
                    a_err_d    = err_q;
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs. Reset abandons any in-flight access.
    // -------------------------------------------------------------------------
    always_ff @(posedge main_clk_i) begin
        if (!main_rst_an_i) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
            wena_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_ena_q  <= 1'b0;
            mem_wena_q <= 1'b0;
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            a_err_q    <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            b_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            err_q      <= err_d;
            wena_q     <= wena_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_ena_q  <= mem_ena_d;
            mem_wena_q <= mem_wena_d;
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            a_err_q    <= a_err_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
            b_err_q    <= b_err_d;
        end
    end

    // Address and write data come straight from the capture registers, so
    // they hold their last captured value outside ACCESS.
    assign mem_ena_o   = mem_ena_q;
    assign mem_wena_o  = mem_wena_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign a_rvalid_o  = a_rvalid_q;
    assign a_rdata_o   = a_rdata_q;
    assign a_err_o     = a_err_q;
    assign b_rvalid_o  = b_rvalid_q;
    assign b_rdata_o   = b_rdata_q;
    assign b_err_o     = b_err_q;

endmodule

// File: tb/tb_uart_regf_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_regf_arb
//
// Directed testbench for uart_regf_arb. Inputs are driven on the falling
// edge; outputs are sampled 1 time unit later, so each sample shows the
// registered outputs of the current cycle and the grant for the inputs just
// applied.
// -----------------------------------------------------------------------------
module tb_uart_regf_arb;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, a_wena, a_gnt, a_rvalid, a_err;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_wena, b_gnt, b_rvalid, b_err;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_ena, mem_wena;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_regf_arb #(
        .AW        (AW),
        .DW        (DW),
        .NUM_WORDS (1)
    ) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_n),
        .a_req_i       (a_req),
        .a_addr_i      (a_addr),
        .a_wena_i      (a_wena),
        .a_wdata_i     (a_wdata),
        .a_gnt_o       (a_gnt),
        .a_rvalid_o    (a_rvalid),
        .a_rdata_o     (a_rdata),
        .a_err_o       (a_err),
        .b_req_i       (b_req),
        .b_addr_i      (b_addr),
        .b_wena_i      (b_wena),
        .b_wdata_i     (b_wdata),
        .b_gnt_o       (b_gnt),
        .b_rvalid_o    (b_rvalid),
        .b_rdata_o     (b_rdata),
        .b_err_o       (b_err),
        .mem_ena_o     (mem_ena),
        .mem_addr_o    (mem_addr),
        .mem_wena_o    (mem_wena),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req = 0; a_addr = '0; a_wena = 0; a_wdata = '0;
        b_req = 0; b_addr = '0; b_wena = 0; b_wdata = '0;
        mem_rdata = '0;
        repeat (2) cyc();
        a_req = 1; b_req = 1;
        #1;
        if ({a_gnt, b_gnt} !== 2'b00) begin
            $display("FAIL rst_gnt: got %b want 00", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        if ({mem_ena, mem_wena, mem_addr, mem_wdata, a_rvalid, a_rdata, a_err,
             b_rvalid, b_rdata, b_err} !== '0) begin
            $display("FAIL rst_outs: ena=%b wena=%b addr=%h wdata=%h arv=%b ard=%h aerr=%b brv=%b brd=%h berr=%b want all 0",
                     mem_ena, mem_wena, mem_addr, mem_wdata, a_rvalid, a_rdata, a_err,
                     b_rvalid, b_rdata, b_err);
            miscompares++;
        end
        vectors++;
        cyc();
        rst_n = 1'b1; a_req = 0; b_req = 0;
    endtask

    task automatic test_single_read();
        cyc();
        a_req = 1; a_addr = 16'h0000; a_wena = 0; mem_rdata = 32'h0000_0001;
        #1;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            $display("FAIL rd_gnt: got %b want 10", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 0;
        #1;
        if ({mem_ena, mem_wena, mem_addr, a_rvalid} !== {2'b10, 16'h0000, 1'b0}) begin
            $display("FAIL rd_access: ena=%b wena=%b addr=%h arv=%b want 1 0 0000 0",
                     mem_ena, mem_wena, mem_addr, a_rvalid);
            miscompares++;
        end
        vectors++;
        cyc();
        #1;
        if (mem_ena !== 1'b0) begin
            $display("FAIL rd_capt_ena: got %b want 0", mem_ena);
            miscompares++;
        end
        vectors++;
        cyc();
        #1;
        if ({a_rvalid, a_err, a_rdata} !== {2'b10, 32'h0000_0001}) begin
            $display("FAIL rd_resp: rv=%b err=%b rdata=%h want 1 0 00000001",
                     a_rvalid, a_err, a_rdata);
            miscompares++;
        end
        vectors++;
        if ({b_rvalid, b_err, b_rdata} !== '0) begin
            $display("FAIL rd_b_quiet: rv=%b err=%b rdata=%h want 0 0 0", b_rvalid, b_err, b_rdata);
            miscompares++;
        end
        vectors++;
        cyc();
        #1;
        if (a_rvalid !== 1'b0) begin
            $display("FAIL rd_rv_pulse: got %b want 0", a_rvalid);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_single_write();
        cyc();
        b_req = 1; b_addr = 16'h0000; b_wena = 1; b_wdata = 32'hA5A5_A5A5;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            $display("FAIL wr_gnt: got %b want 01", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        b_req = 0; b_wdata = 32'h0;
        #1;
        if ({mem_ena, mem_wena, mem_wdata} !== {2'b11, 32'hA5A5_A5A5}) begin
            $display("FAIL wr_access: ena=%b wena=%b wdata=%h want 1 1 a5a5a5a5",
                     mem_ena, mem_wena, mem_wdata);
            miscompares++;
        end
        vectors++;
        cyc(); cyc();
        #1;
        if ({b_rvalid, b_err, b_rdata, a_rvalid} !== {2'b10, 32'h0, 1'b0}) begin
            $display("FAIL wr_resp: brv=%b berr=%b brd=%h arv=%b want 1 0 0 0",
                     b_rvalid, b_err, b_rdata, a_rvalid);
            miscompares++;
        end
        vectors++;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        a_req = 1; a_addr = '0; a_wena = 0;
        b_req = 1; b_addr = '0; b_wena = 0;
        mem_rdata = 32'h0000_1234;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) cyc();
            #1;
            exp = {(i % 4 == 0) && ((i / 4) % 2 == 0), (i % 4 == 0) && ((i / 4) % 2 == 1),
                   (i % 4 == 3) && ((i / 4) % 2 == 0), (i % 4 == 3) && ((i / 4) % 2 == 1)};
            if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== exp) begin
                $display("FAIL rr_cycle%0d: agnt/bgnt/arv/brv got %b want %b",
                         i, {a_gnt, b_gnt, a_rvalid, b_rvalid}, exp);
                miscompares++;
            end
            vectors++;
        end
        cyc();
        a_req = 0; b_req = 0;
    endtask

    task automatic test_error();
        cyc();
        a_req = 1; a_addr = 16'h0005; a_wena = 0; mem_rdata = 32'hFFFF_FFFF;
        #1;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            $display("FAIL err_gnt: got %b want 10", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 0;
        #1;
        if ({mem_ena, mem_wena, mem_addr} !== {2'b00, 16'h0005}) begin
            $display("FAIL err_access: ena=%b wena=%b addr=%h want 0 0 0005",
                     mem_ena, mem_wena, mem_addr);
            miscompares++;
        end
        vectors++;
        cyc(); cyc();
        #1;
        if ({a_rvalid, a_err, a_rdata} !== {2'b11, 32'h0}) begin
            $display("FAIL err_resp: rv=%b err=%b rdata=%h want 1 1 0", a_rvalid, a_err, a_rdata);
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 1; a_addr = '0; b_req = 1; b_addr = '0; b_wena = 0;
        #1;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            $display("FAIL err_next_gnt: got %b want 01", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 0; b_req = 0;
        cyc(); cyc();
        #1;
        if ({b_rvalid, b_err, b_rdata} !== {2'b10, 32'hFFFF_FFFF}) begin
            $display("FAIL err_b_resp: rv=%b err=%b rdata=%h want 1 0 ffffffff",
                     b_rvalid, b_err, b_rdata);
            miscompares++;
        end
        vectors++;
        cyc();
    endtask

    task automatic test_late_b();
        cyc();
        a_req = 1; a_addr = '0; a_wena = 0; mem_rdata = 32'h0000_00C3;
        #1;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            $display("FAIL late_a_gnt: got %b want 10", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 0; b_req = 1; b_addr = '0; b_wena = 1; b_wdata = 32'h0000_0001;
        for (int k = 1; k <= 3; k++) begin
            if (k != 1) cyc();
            #1;
            if ({a_gnt, b_gnt} !== 2'b00) begin
                $display("FAIL late_wait%0d: got %b want 00", k, {a_gnt, b_gnt});
                miscompares++;
            end
            vectors++;
        end
        if ({a_rvalid, a_err, a_rdata} !== {2'b10, 32'h0000_00C3}) begin
            $display("FAIL late_a_resp: rv=%b err=%b rdata=%h want 1 0 000000c3",
                     a_rvalid, a_err, a_rdata);
            miscompares++;
        end
        vectors++;
        cyc();
        #1;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            $display("FAIL late_b_gnt: got %b want 01", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        b_req = 0;
        #1;
        if ({mem_ena, mem_wena, mem_wdata} !== {2'b11, 32'h0000_0001}) begin
            $display("FAIL late_b_access: ena=%b wena=%b wdata=%h want 1 1 00000001",
                     mem_ena, mem_wena, mem_wdata);
            miscompares++;
        end
        vectors++;
        cyc(); cyc();
        #1;
        if (b_rvalid !== 1'b1) begin
            $display("FAIL late_b_resp: rv=%b want 1", b_rvalid);
            miscompares++;
        end
        vectors++;
        cyc();
    endtask

    task automatic test_reset_midflight();
        cyc();
        a_req = 1; a_addr = '0; a_wena = 0; a_wdata = 32'h0000_005A; mem_rdata = 32'h0000_0077;
        #1;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            $display("FAIL mid_gnt: got %b want 10", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 0;
        #1;
        if ({mem_ena, mem_wdata} !== {1'b1, 32'h0000_005A}) begin
            $display("FAIL mid_access: ena=%b wdata=%h want 1 0000005a", mem_ena, mem_wdata);
            miscompares++;
        end
        vectors++;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k != 0) cyc();
            #1;
            if ({mem_ena, mem_wena, mem_addr, mem_wdata, a_rvalid, a_rdata, a_err,
                 b_rvalid, b_rdata, b_err} !== '0) begin
                $display("FAIL mid_outs%0d: ena=%b wena=%b addr=%h wdata=%h arv=%b ard=%h aerr=%b brv=%b want all 0",
                         k, mem_ena, mem_wena, mem_addr, mem_wdata, a_rvalid, a_rdata, a_err, b_rvalid);
                miscompares++;
            end
            vectors++;
        end
        cyc();
        a_req = 1; b_req = 1; a_addr = '0; b_addr = '0; b_wena = 0;
        #1;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            $display("FAIL mid_ptr_gnt: got %b want 10", {a_gnt, b_gnt});
            miscompares++;
        end
        vectors++;
        cyc();
        a_req = 0; b_req = 0;
        cyc(); cyc();
        #1;
        if ({a_rvalid, a_rdata} !== {1'b1, 32'h0000_0077}) begin
            $display("FAIL mid_a_resp: rv=%b rdata=%h want 1 00000077", a_rvalid, a_rdata);
            miscompares++;
        end
        vectors++;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_error();
        test_late_b();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_regf_arb.md
# uart_regf_arb

Two-port arbiter and access sequencer for the UART register file's memory-style bus (ena/addr/wena/wdata/rdata). It sits between two requesters and the single regf bus port: port A is the host bus bridge and port B is the UART core's internal configuration sequencer. It grants one access at a time in round-robin order and drives a single regf access. It returns read data or an error response to the granted requester after a fixed latency.

## Interface
Parameters:
- AW, 16, address width (word address, matches regf mem_addr).
- DW, 32, data width.
- NUM_WORDS, 1, number of implemented regf words; addresses >= NUM_WORDS are errors.

Ports:
- main_clk_i  in  1  clock.
- main_rst_an_i  in  1  reset, synchronous, active-low.
- a_req_i  in  1  port A request; held with addr/wena/wdata stable until a_gnt_o.
- a_addr_i  in  AW  port A word address.
- a_wena_i  in  1  port A write enable (1 = write, 0 = read).
- a_wdata_i  in  DW  port A write data.
- a_gnt_o  out  1  port A request accepted (1-cycle pulse).
- a_rvalid_o  out  1  port A response valid (1-cycle pulse).
- a_rdata_o  out  DW  port A read data; 0 for writes and errors.
- a_err_o  out  1  port A error, qualified by a_rvalid_o.
- b_req_i, b_addr_i, b_wena_i, b_wdata_i, b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o: identical set for port B.
- mem_ena_o  out  1  regf access strobe.
- mem_addr_o  out  AW  regf word address.
- mem_wena_o  out  1  regf write strobe.
- mem_wdata_o  out  DW  regf write data.
- mem_rdata_i  in  DW  regf read data; valid in the cycle after mem_ena_o.

## Operation
- FSM states: IDLE, ACCESS, CAPT, RESP.
- IDLE:
  - If any req is high, select the winner and assert its gnt combinationally.
  - Register the winner's addr/wena/wdata, the winner ID, and err = (addr >= NUM_WORDS).
  - Go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_ena_o = ~err.
  - mem_wena_o = ~err & wena.
  - mem_addr_o and mem_wdata_o come from the capture registers.
  - Go to CAPT.
- CAPT:
  - Register rdata = (~err & ~wena) ? mem_rdata_i : 0.
  - Go to RESP.
- RESP:
  - Assert the winner's rvalid_o with the registered rdata and err.
  - Go to IDLE.
- The non-winning port's rvalid_o, rdata_o and err_o are 0.
- Arbitration:
  - Round-robin pointer; after reset port A holds priority.
  - A single requester always wins.
  - When both request, the priority holder wins.
  - After any grant, priority passes to the port not granted.
  - Error accesses update the pointer like normal accesses.
- gnt is only ever asserted in IDLE. A req raised in ACCESS/CAPT/RESP waits; no request is lost or reordered.
- A requester may drop req before gnt with no effect. After gnt it may drop req or change its inputs immediately.
- mem_addr_o and mem_wdata_o hold their last captured value outside ACCESS. mem_ena_o and mem_wena_o are high only in ACCESS.
- Reset (main_rst_an_i low at a clock edge):
  - State returns to IDLE; pointer returns to A.
  - All registered outputs and capture registers go to 0.
  - gnt outputs are forced to 0 while reset is low.
  - An in-flight access is abandoned; no rvalid is issued for it.

## Timing
- Grant in cycle N; mem_ena_o in N+1; mem_rdata_i sampled at the end of N+2; rvalid_o in N+3.
- Next grant earliest in N+4. Throughput is one access per 4 cycles.
- Error accesses keep the same latency with mem_ena_o = 0.
- Reset values: mem_ena_o=0, mem_wena_o=0, mem_addr_o=0, mem_wdata_o=0, *_gnt_o=0, *_rvalid_o=0, *_rdata_o=0, *_err_o=0.
- All outputs except gnt are registered. gnt is combinational from state, pointer and req.

## Test plan
- Reset, then single A read of addr 0 with regf returning 0x0000_0001 -> a_gnt_o at N, mem_ena_o=1/mem_wena_o=0/mem_addr_o=0 at N+1, a_rvalid_o=1/a_rdata_o=0x1/a_err_o=0 at N+3; b outputs stay 0.
- B write addr 0 data 0xA5A5_A5A5 -> mem_wena_o=1, mem_wdata_o=0xA5A5_A5A5 at N+1; b_rvalid_o at N+3 with rdata 0, err 0.
- A and B both request continuously from reset -> grants alternate A,B,A,B at cycles 0,4,8,12; each rvalid arrives 3 cycles after its grant.
- A read of addr 0x0005 (NUM_WORDS=1) -> a_gnt_o at N, mem_ena_o stays 0, a_rvalid_o=1/a_err_o=1/a_rdata_o=0 at N+3; next simultaneous request is granted to B.
- B request raised during A's ACCESS -> b_gnt_o only at A's N+4, not earlier; A's response is unaffected.
- main_rst_an_i low for 1 cycle during CAPT of an A read -> no a_rvalid_o; all outputs 0 next cycle; a subsequent simultaneous A+B request grants A first.
